// File: rtl/qkv_proj_mac.sv
// qkv_proj_mac: Q/K/V projection engine. Three serial MAC lanes (one per
// matrix) share the latched token vector and the (row, col) sequencer.
// Each lane owns its weight memory, accumulator and rounding/convert stage.
// Optional feature macro: QKV_SAT_EN (saturating convert instead of wrap).

module qkv_proj_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int EMBED_DIM  = 64,
    parameter int FRAC_BITS  = 14,
    parameter int ACC_WIDTH  = 40,
    parameter int AW         = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    input  logic [DATA_WIDTH-1:0] x_elem,
    input  logic                  mac_en,
    input  logic                  acc_clr,
    output logic [DATA_WIDTH-1:0] y
);
    localparam logic signed [ACC_WIDTH-1:0] HALF    = ACC_WIDTH'(64'sd1 <<< (FRAC_BITS-1));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

    logic        [DATA_WIDTH-1:0]   wmem [EMBED_DIM*EMBED_DIM];
    logic signed [DATA_WIDTH-1:0]   w_s, x_s;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc, rnd;

    // Weight storage: not reset, survives rst so the host loads once.
    always_ff @(posedge clk) begin
        if (we) wmem[waddr] <= wdata;
    end

    assign w_s  = signed'(wmem[raddr]);
    assign x_s  = signed'(x_elem);
    assign prod = x_s * w_s;

    // Accumulator: cleared on run start and after every row writeback.
    always_ff @(posedge clk) begin
        if (rst)          acc <= '0;
        else if (acc_clr) acc <= '0;
        else if (mac_en)  acc <= acc + ACC_WIDTH'(prod);
    end

    // Round half toward +inf, then narrow to DATA_WIDTH.
    always_comb begin
        rnd = (acc + HALF) >>> FRAC_BITS;
`ifdef QKV_SAT_EN
        if (rnd > SAT_MAX)      y = SAT_MAX[DATA_WIDTH-1:0];
        else if (rnd < SAT_MIN) y = SAT_MIN[DATA_WIDTH-1:0];
        else                    y = rnd[DATA_WIDTH-1:0];
`else
        y = rnd[DATA_WIDTH-1:0];
`endif
    end
endmodule

module qkv_proj_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int EMBED_DIM  = 64,
    parameter int FRAC_BITS  = 14,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [DATA_WIDTH*EMBED_DIM-1:0] input_vec_flat,
    input  logic                            w_we,
    input  logic [1:0]                      w_sel,
    input  logic [$clog2(EMBED_DIM*EMBED_DIM)-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0]           w_data,
    output logic                            busy,
    output logic                            done,
    output logic [DATA_WIDTH*EMBED_DIM-1:0] Q_flat,
    output logic [DATA_WIDTH*EMBED_DIM-1:0] K_flat,
    output logic [DATA_WIDTH*EMBED_DIM-1:0] V_flat
);
    localparam int AW = $clog2(EMBED_DIM*EMBED_DIM);
    localparam int CW = $clog2(EMBED_DIM);
    localparam logic [CW-1:0] LAST = CW'(EMBED_DIM-1);
    localparam logic [AW:0]   DD   = (AW+1)'(EMBED_DIM*EMBED_DIM);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;
    state_t state, nxt;

    logic [CW-1:0] r, c;
    logic [EMBED_DIM-1:0][DATA_WIDTH-1:0]      x_q;
    logic [2:0][EMBED_DIM-1:0][DATA_WIDTH-1:0] proj;
    logic [2:0][DATA_WIDTH-1:0]                y;
    logic          accept, wr_ok, mac_en, acc_clr;
    logic [AW-1:0] raddr;

    assign accept  = (state == S_IDLE) && start;
    assign wr_ok   = (state == S_IDLE) && w_we && ({1'b0, w_addr} < DD);
    assign mac_en  = (state == S_MAC);
    assign acc_clr = accept || (state == S_WB);
    assign raddr   = AW'(r) * AW'(EMBED_DIM) + AW'(c);
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    // Next-state: one MAC pass per row, one writeback cycle per row.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (start) nxt = S_MAC;
            S_MAC:  if (c == LAST) nxt = S_WB;
            S_WB:   nxt = (r == LAST) ? S_DONE : S_MAC;
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Row/column sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    r <= '0;
                    c <= '0;
                end
                S_MAC: c <= (c == LAST) ? '0 : c + 1'b1;
                S_WB: begin
                    c <= '0;
                    if (r != LAST) r <= r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Token vector is captured once per run so the source may change freely.
    always_ff @(posedge clk) begin
        if (rst)         x_q <= '0;
        else if (accept) x_q <= input_vec_flat;
    end

    for (genvar m = 0; m < 3; m++) begin : g_lane
        qkv_proj_lane #(
            .DATA_WIDTH(DATA_WIDTH), .EMBED_DIM(EMBED_DIM),
            .FRAC_BITS(FRAC_BITS), .ACC_WIDTH(ACC_WIDTH), .AW(AW)
        ) u_lane (
            .clk(clk), .rst(rst),
            .we(wr_ok && (w_sel == 2'(m))),
            .waddr(w_addr), .wdata(w_data),
            .raddr(raddr), .x_elem(x_q[c]),
            .mac_en(mac_en), .acc_clr(acc_clr),
            .y(y[m])
        );
    end

    // Result registers: element r is rewritten at its writeback, others hold.
    always_ff @(posedge clk) begin
        if (rst) proj <= '0;
        else if (state == S_WB) begin
            for (int m = 0; m < 3; m++) proj[m][r] <= y[m];
        end
    end

    assign Q_flat = proj[0];
    assign K_flat = proj[1];
    assign V_flat = proj[2];
endmodule
